// File: rtl/taumin_packetizer.sv
// Frames each pitch-period estimate as SYNC, HI, LO (optionally CHK) bytes for a byte-wide UART.
// Define TAUMIN_PKT_CHECKSUM_EN to append the XOR checksum byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no packet active; waits for a pending word and UART idle
// SEND    | presents byte[idx] to the UART (trigger registered out)
// GAP     | one-cycle settle so the UART busy flag can rise
// WAIT    | waits for UART busy low, then next byte or back to IDLE
module taumin_packetizer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TAU_WIDTH = 11
) (
    input  logic                 clk_in,
    input  logic                 rst_in_n,
    input  logic [TAU_WIDTH-1:0] taumin_in,
    input  logic                 taumin_valid_in,
    input  logic                 busy_in,
    output logic [7:0]           byte_out,
    output logic                 byte_valid_out,
    output logic                 pkt_busy_out,
    output logic [7:0]           drop_count_out
);

`ifdef TAUMIN_PKT_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic                 load_shadow;
    logic                 pend_flag_q;
    logic [TAU_WIDTH-1:0] pend_q;
    logic [TAU_WIDTH-1:0] shadow_q;
    logic [15:0]          shadow_ext;
    logic [7:0]           hi_byte;
    logic [7:0]           lo_byte;
    logic [7:0]           cur_byte;

    assign shadow_ext = 16'(shadow_q);
    assign hi_byte    = shadow_ext[15:8];
    assign lo_byte    = shadow_ext[7:0];

    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            2'd0:    cur_byte = SYNC_BYTE;
            2'd1:    cur_byte = hi_byte;
            2'd2:    cur_byte = lo_byte;
`ifdef TAUMIN_PKT_CHECKSUM_EN
            default: cur_byte = SYNC_BYTE ^ hi_byte ^ lo_byte;
`else
            default: cur_byte = 8'h00;
`endif
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        load_shadow = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_flag_q && !busy_in) begin
                    state_d     = ST_SEND;
                    idx_d       = 2'd0;
                    load_shadow = 1'b1;
                end
            end
            ST_SEND: state_d = ST_GAP;
            ST_GAP:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (!busy_in) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // A strobe coinciding with the shadow load refills pending without counting a drop.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            pend_flag_q    <= 1'b0;
            pend_q         <= '0;
            shadow_q       <= '0;
            drop_count_out <= 8'h00;
        end else begin
            if (taumin_valid_in) begin
                pend_q      <= taumin_in;
                pend_flag_q <= 1'b1;
                if (pend_flag_q && !load_shadow && (drop_count_out != 8'hFF)) begin
                    drop_count_out <= drop_count_out + 8'd1;
                end
            end else if (load_shadow) begin
                pend_flag_q <= 1'b0;
            end
            if (load_shadow) begin
                shadow_q <= pend_q;
            end
        end
    end

    // Trigger and data are registered out of SEND, so they appear during GAP.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            byte_out       <= 8'h00;
            byte_valid_out <= 1'b0;
        end else begin
            byte_valid_out <= (state_q == ST_SEND);
            if (state_q == ST_SEND) begin
                byte_out <= cur_byte;
            end
        end
    end

    assign pkt_busy_out = (state_q != ST_IDLE) || pend_flag_q;

endmodule

// File: tb/tb_taumin_packetizer.sv
// Bench for taumin_packetizer: event-scheduled reference model plus directed scenarios.
// Honours TAUMIN_PKT_CHECKSUM_EN to expect the checksum byte.
module tb_taumin_packetizer;

`ifdef TAUMIN_PKT_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in_n = 1'b0;
    logic [10:0] taumin_in = '0;
    logic        taumin_valid_in = 1'b0;
    logic        busy_in = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid_out;
    logic        pkt_busy_out;
    logic [7:0]  drop_count_out;

    taumin_packetizer #(.SYNC_BYTE(8'hA5), .TAU_WIDTH(11)) dut (
        .clk_in          (clk_in),
        .rst_in_n        (rst_in_n),
        .taumin_in       (taumin_in),
        .taumin_valid_in (taumin_valid_in),
        .busy_in         (busy_in),
        .byte_out        (byte_out),
        .byte_valid_out  (byte_valid_out),
        .pkt_busy_out    (pkt_busy_out),
        .drop_count_out  (drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Model: packet bytes still to go, edge number of the next emission, edge from which
    // a low busy lets the packet advance, and the pending word with its drop tally.
    int         cyc = 0;
    logic [7:0] m_q[$];
    bit         m_active = 0;
    int         emit_at = -1;
    int         listen_from = -1;
    bit         m_pend_v = 0;
    logic [10:0] m_pend_val = '0;
    int         m_drops = 0;
    bit         exp_valid = 0;
    logic [7:0] exp_byte = '0;

    logic [7:0] obs_b[$];
    int         obs_c[$];
    int         strobe_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic void build_pkt(input logic [10:0] t);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = {5'd0, t[10:8]};
        lo = t[7:0];
        m_q.delete();
        m_q.push_back(8'hA5);
        m_q.push_back(hi);
        m_q.push_back(lo);
`ifdef TAUMIN_PKT_CHECKSUM_EN
        m_q.push_back(8'hA5 ^ hi ^ lo);
`endif
    endfunction

    initial forever begin
        bit start;
        @(posedge clk_in or negedge rst_in_n);
        if (!rst_in_n) begin
            m_q.delete();
            m_active = 0; emit_at = -1; listen_from = -1;
            m_pend_v = 0; m_pend_val = '0; m_drops = 0;
            exp_valid = 0; exp_byte = '0;
        end else begin
            cyc++;
            start = 0;
            exp_valid = 0;
            if (!m_active) begin
                if (m_pend_v && !busy_in) begin
                    start = 1;
                    m_active = 1;
                    build_pkt(m_pend_val);
                    emit_at = cyc + 1;
                end
            end else if (cyc == emit_at) begin
                exp_valid = 1;
                exp_byte = m_q.pop_front();
                emit_at = -1;
                listen_from = cyc + 2;
            end else if (listen_from >= 0 && cyc >= listen_from && !busy_in) begin
                listen_from = -1;
                if (m_q.size() == 0) m_active = 0;
                else emit_at = cyc + 1;
            end
            if (taumin_valid_in) begin
                if (m_pend_v && !start && m_drops < 255) m_drops++;
                m_pend_v = 1;
                m_pend_val = taumin_in;
            end else if (start) begin
                m_pend_v = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (rst_in_n) begin
            chk("byte_valid", {31'd0, byte_valid_out}, {31'd0, exp_valid});
            chk("byte_out", {24'd0, byte_out}, {24'd0, exp_byte});
            chk("pkt_busy", {31'd0, pkt_busy_out}, {31'd0, (m_active || m_pend_v)});
            chk("drop_count", {24'd0, drop_count_out}, 32'(m_drops));
            if (byte_valid_out) begin
                obs_b.push_back(byte_out);
                obs_c.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic strobe(input logic [10:0] v);
        taumin_in = v;
        taumin_valid_in = 1'b1;
        tick();
        strobe_cyc = cyc;
        taumin_valid_in = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && obs_b.size() < n; i++) tick();
        chk("bytes_arrived", 32'(obs_b.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && pkt_busy_out; i++) tick();
        chk("returned_idle", {31'd0, pkt_busy_out}, 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_byte_out"}, {24'd0, byte_out}, 32'd0);
        chk({tag, "_byte_valid"}, {31'd0, byte_valid_out}, 32'd0);
        chk({tag, "_pkt_busy"}, {31'd0, pkt_busy_out}, 32'd0);
        chk({tag, "_drop_count"}, {24'd0, drop_count_out}, 32'd0);
    endtask

    logic [7:0] pkt_a[4] = '{8'hA5, 8'h03, 8'hC7, 8'h61};
    logic [7:0] pkt_b[4] = '{8'hA5, 8'h07, 8'hFF, 8'h5D};

    initial begin
        logic [10:0] last_v;
        int fall_cyc;

        repeat (3) @(posedge clk_in);
        #2 chk_zero_outputs("reset");
        @(negedge clk_in) rst_in_n = 1'b1;
        repeat (20) tick();
        chk("no_bytes_after_reset", 32'(obs_b.size()), 32'd0);

        strobe(11'h3C7);
        wait_bytes(NB, 60);
        if (obs_b.size() >= NB) begin
            for (int i = 0; i < NB; i++) chk("pkt_3c7_byte", {24'd0, obs_b[i]}, {24'd0, pkt_a[i]});
            chk("first_trigger_latency", 32'(obs_c[0] - strobe_cyc), 32'd2);
        end
        wait_idle(40);

        obs_b.delete(); obs_c.delete();
        strobe(11'h7FF);
        wait_bytes(NB, 60);
        if (obs_b.size() >= NB)
            for (int i = 0; i < NB; i++) chk("pkt_7ff_byte", {24'd0, obs_b[i]}, {24'd0, pkt_b[i]});
        wait_idle(40);
        chk("drop_before_overwrite", {24'd0, drop_count_out}, 32'd0);

        // 010 lands on the shadow-load edge (no drop); 020 and 030 each overwrite.
        obs_b.delete(); obs_c.delete();
        strobe(11'h005);
        strobe(11'h010);
        strobe(11'h020);
        strobe(11'h030);
        wait_bytes(2 * NB, 120);
        if (obs_b.size() >= 2 * NB) begin
            chk("first_pkt_lo", {24'd0, obs_b[2]}, 32'h05);
            chk("next_pkt_hi", {24'd0, obs_b[NB + 1]}, 32'h00);
            chk("next_pkt_lo", {24'd0, obs_b[NB + 2]}, 32'h30);
        end
        chk("drop_after_overwrite", {24'd0, drop_count_out}, 32'd2);
        wait_idle(40);

        obs_b.delete(); obs_c.delete();
        strobe(11'h155);
        wait_bytes(2, 40);
        busy_in = 1'b1;
        repeat (500) tick();
        chk("stall_no_byte", 32'(obs_b.size()), 32'd2);
        fall_cyc = cyc;
        busy_in = 1'b0;
        wait_bytes(NB, 60);
        if (obs_b.size() >= 3) begin
            chk("third_after_fall", 32'(obs_c[2] > fall_cyc), 32'd1);
            chk("third_byte", {24'd0, obs_b[2]}, 32'h55);
        end
        wait_idle(40);

        obs_b.delete(); obs_c.delete();
        strobe(11'h2AB);
        for (int i = 0; i < 60 && obs_b.size() < 2; i++) begin
            @(negedge clk_in);
            #1;
        end
        chk("reached_gap_byte2", 32'(obs_b.size()), 32'd2);
        #1 rst_in_n = 1'b0;
        #1 chk_zero_outputs("mid_reset");
        repeat (3) @(posedge clk_in);
        @(negedge clk_in) rst_in_n = 1'b1;
        repeat (60) tick();
        chk("no_bytes_after_mid_reset", 32'(obs_b.size()), 32'd2);
        chk("idle_after_mid_reset", {31'd0, pkt_busy_out}, 32'd0);

        busy_in = 1'b1;
        last_v = '0;
        for (int i = 0; i < 300; i++) begin
            last_v = 11'($urandom);
            strobe(last_v);
        end
        chk("drop_saturated", {24'd0, drop_count_out}, 32'd255);
        chk("no_bytes_while_busy", 32'(obs_b.size()), 32'd2);
        busy_in = 1'b0;
        wait_bytes(2 + NB, 60);
        if (obs_b.size() >= 2 + NB) begin
            chk("sat_pkt_hi", {24'd0, obs_b[3]}, {29'd0, last_v[10:8]});
            chk("sat_pkt_lo", {24'd0, obs_b[4]}, {24'd0, last_v[7:0]});
        end
        wait_idle(40);

        @(negedge clk_in) rst_in_n = 1'b0;
        @(negedge clk_in) rst_in_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            taumin_in = 11'($urandom);
            taumin_valid_in = ($urandom_range(0, 7) == 0);
            busy_in = ($urandom_range(0, 2) == 0);
            tick();
        end
        taumin_valid_in = 1'b0;
        busy_in = 1'b0;
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
